// File: rtl/kara_gf2_mul_seq_if.sv
// Operand/result handshake bundle for the sequential Karatsuba GF(2)[x] multiplier.
// The master drives the operands and out_ready; the slave returns in_ready, out_valid and y.
interface kara_gf2_mul_seq_if #(
  parameter int W = 193
);
  localparam int PW = 2 * W - 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          reduce;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] y;

  modport master (
    output in_valid, a, b, reduce, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, reduce, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/kara_gf2_mul_seq.sv
// Time-multiplexed one-level Karatsuba carry-less multiplier, optional reduction mod x^W + POLY.
// Latency 4 cycles raw / 5 reduced; one op in flight, y held while out_ready is low.
module kara_gf2_mul_seq #(
  parameter int           W    = 193,
  parameter logic [W-1:0] POLY = W'(16'h8001)
) (
  input  logic               clk,
  input  logic               rst_n,
  kara_gf2_mul_seq_if.slave  io
);
  localparam int H  = (W + 1) / 2;
  localparam int PW = 2 * W - 1;
  localparam int HP = 2 * H - 1;

  typedef enum logic [2:0] {
    IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE, REDUCE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          red_q, red_d;
  logic [HP-1:0] pl_q, pl_d, ph_q, ph_d, pm_q, pm_d;
  logic [PW-1:0] y_q, y_d;

  logic [H-1:0]  a_lo, a_hi, a_mid, b_lo, b_hi, b_mid;
  logic [H-1:0]  op_x, op_z;
  logic [HP-1:0] mul_p, p1;
  logic [PW-1:0] prod;

  function automatic logic [HP-1:0] clmul_h(input logic [H-1:0] x, input logic [H-1:0] z);
    logic [HP-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++) begin
      if (z[i]) r = r ^ (HP'(x) << i);
    end
    return r;
  endfunction

  // Top-down fold: POLY << (k-W) only touches bits below k, so one pass clears all bits >= W.
  function automatic logic [PW-1:0] fold(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int k = PW - 1; k >= W; k--) begin
      if (r[k]) begin
        r[k] = 1'b0;
        r    = r ^ (PW'(POLY) << (k - W));
      end
    end
    return r;
  endfunction

  always_comb begin
    a_lo = a_q[H-1:0];
    b_lo = b_q[H-1:0];
    a_hi = '0;
    b_hi = '0;
    a_hi[W-H-1:0] = a_q[W-1:H];
    b_hi[W-H-1:0] = b_q[W-1:H];
    a_mid = a_lo ^ a_hi;
    b_mid = b_lo ^ b_hi;

    case (state_q)
      MUL_HI:  begin op_x = a_hi;  op_z = b_hi;  end
      MUL_MID: begin op_x = a_mid; op_z = b_mid; end
      default: begin op_x = a_lo;  op_z = b_lo;  end
    endcase
    mul_p = clmul_h(op_x, op_z);

    p1   = pm_q ^ pl_q ^ ph_q;
    prod = PW'(pl_q) ^ (PW'(p1) << H) ^ (PW'(ph_q) << (2 * H));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    red_d   = red_q;
    pl_d    = pl_q;
    ph_d    = ph_q;
    pm_d    = pm_q;
    y_d     = y_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          red_d   = io.reduce;
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        pl_d    = mul_p;
        state_d = MUL_HI;
      end
      MUL_HI: begin
        ph_d    = mul_p;
        state_d = MUL_MID;
      end
      MUL_MID: begin
        pm_d    = mul_p;
        state_d = COMBINE;
      end
      COMBINE: begin
        y_d     = prod;
        state_d = red_q ? REDUCE : DONE;
      end
      REDUCE: begin
        y_d     = fold(y_q);
        state_d = DONE;
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      red_q   <= 1'b0;
      pl_q    <= '0;
      ph_q    <= '0;
      pm_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      red_q   <= red_d;
      pl_q    <= pl_d;
      ph_q    <= ph_d;
      pm_q    <= pm_d;
      y_q     <= y_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.y         = y_q;
endmodule

// File: tb/tb_kara_gf2_mul_seq.sv
// Directed checks of kara_gf2_mul_seq at W=193 and W=8 (AES field), plus a schoolbook reference for random ops.
module tb_kara_gf2_mul_seq;
  localparam int W  = 193;
  localparam int PW = 2 * W - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kara_gf2_mul_seq_if #(.W(W)) io();
  kara_gf2_mul_seq #(.W(W), .POLY(193'h8001)) dut (.clk(clk), .rst_n(rst_n), .io(io.slave));

  kara_gf2_mul_seq_if #(.W(8)) io8();
  kara_gf2_mul_seq #(.W(8), .POLY(8'h1B)) dut8 (.clk(clk), .rst_n(rst_n), .io(io8.slave));

  int checks   = 0;
  int failures = 0;

  function automatic logic [384:0] ref_mul(input logic [192:0] x, input logic [192:0] z,
                                           input int w, input logic [192:0] poly, input bit red);
    logic [384:0] p;
    p = '0;
    for (int i = 0; i < w; i++) if (z[i]) p = p ^ (385'(x) << i);
    if (red) begin
      for (int k = 2 * w - 2; k >= w; k--) begin
        if (p[k]) begin
          p[k] = 1'b0;
          p    = p ^ (385'(poly) << (k - w));
        end
      end
    end
    return p;
  endfunction

  function automatic logic [192:0] rnd193();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    return t[192:0];
  endfunction

  // Drivers for the W=193 instance; entered and left away from the rising edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] z, input bit red, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (io.in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      io.in_valid = 1'b1; io.a = x; io.b = z; io.reduce = red;
      @(posedge clk);
      #1 io.in_valid = 1'b0;
    end
  endtask

  task automatic get(output logic [PW-1:0] yv, output int lat);
    lat = -1;
    yv  = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (io.out_valid) begin lat = n; yv = io.y; break; end
    end
  endtask

  task automatic ack();
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] z, input bit red,
                        output logic [PW-1:0] yv, output int lat);
    bit ok;
    send(x, z, red, ok);
    if (!ok) begin
      lat = -1; yv = '0;
    end else begin
      get(yv, lat);
      if (lat > 0) begin
        @(negedge clk);
        ack();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io.in_valid = 0; io.a = '0; io.b = '0; io.reduce = 0; io.out_ready = 0;
    io8.in_valid = 0; io8.a = '0; io8.b = '0; io8.reduce = 0; io8.out_ready = 0;
    #12;
    checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", io.out_valid); end
    checks++; if (io.y !== '0) begin failures++; $display("FAIL reset_y got %h exp 0", io.y); end
    checks++; if (io8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready8 got %b exp 1", io8.in_ready); end
    #10 rst_n = 1'b1;
  endtask

  task automatic test_raw_one();
    logic [PW-1:0] yv; int lat;
    run_op(193'd1, 193'd1, 1'b0, yv, lat);
    checks++; if (yv !== PW'(1)) begin failures++; $display("FAIL one_y got %h exp 1", yv); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL one_latency got %0d exp 4", lat); end
    @(negedge clk);
    checks++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
      failures++; $display("FAIL one_return_idle got in_ready=%b out_valid=%b exp 1/0", io.in_ready, io.out_valid);
    end
  endtask

  task automatic test_reduce();
    logic [PW-1:0] yv, exp_v; int lat;
    logic [W-1:0] top;
    top = '0; top[192] = 1'b1;
    run_op(top, top, 1'b0, yv, lat);
    exp_v = '0; exp_v[384] = 1'b1;
    checks++; if (yv !== exp_v) begin failures++; $display("FAIL x192sq_raw got %h exp %h", yv, exp_v); end
    run_op(top, top, 1'b1, yv, lat);
    exp_v = '0; exp_v[191] = 1'b1; exp_v[28] = 1'b1; exp_v[13] = 1'b1;
    checks++; if (yv !== exp_v) begin failures++; $display("FAIL x192sq_red got %h exp %h", yv, exp_v); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL red_latency got %0d exp 5", lat); end
  endtask

  task automatic test_square();
    logic [PW-1:0] yv, exp_v; int lat;
    exp_v = '0;
    for (int i = 0; i < PW; i += 2) exp_v[i] = 1'b1;
    run_op({W{1'b1}}, {W{1'b1}}, 1'b0, yv, lat);
    checks++; if (yv !== exp_v) begin failures++; $display("FAIL ones_square got %h exp %h", yv, exp_v); end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] yv; int lat; bit ok; bit spurious;
    send(193'd3, 193'd5, 1'b0, ok);
    get(yv, lat);
    checks++; if (yv !== PW'(15) || lat !== 4) begin failures++; $display("FAIL bp_first got y=%h lat=%0d exp 15/4", yv, lat); end
    io.in_valid = 1'b1; io.a = 193'd7; io.b = 193'd7; io.reduce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (io.y !== PW'(15)) begin failures++; $display("FAIL bp_hold_y cycle %0d got %h exp 15", i, io.y); end
      checks++; if (io.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cycle %0d got %b exp 1", i, io.out_valid); end
      checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", i, io.in_ready); end
    end
    io.in_valid = 1'b0;
    ack();
    spurious = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) spurious = 1'b1;
    end
    checks++; if (spurious) begin failures++; $display("FAIL bp_no_accept got extra activity exp idle"); end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] yv; int lat; bit ok; bit spurious;
    send(193'd6, 193'd7, 1'b0, ok);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_immediate got out_valid=%b in_ready=%b exp 0/1", io.out_valid, io.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0) spurious = 1'b1;
    end
    checks++; if (spurious) begin failures++; $display("FAIL rst_mid_spurious got out_valid pulse exp none"); end
    run_op(193'd3, 193'd5, 1'b0, yv, lat);
    checks++; if (yv !== PW'(15) || lat !== 4) begin failures++; $display("FAIL rst_mid_next got y=%h lat=%0d exp 15/4", yv, lat); end
  endtask

  task automatic test_back_to_back(input bit red);
    int first, second; bit seen_y; logic [PW-1:0] y_first;
    first = -1; second = -1; seen_y = 1'b0; y_first = '0;
    @(negedge clk);
    io.a = 193'd3; io.b = 193'd5; io.reduce = red;
    io.in_valid = 1'b1; io.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (io.in_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (io.out_valid && !seen_y) begin seen_y = 1'b1; y_first = io.y; end
    end
    io.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    io.out_ready = 1'b0;
    checks++; if ((second - first) !== (red ? 7 : 6)) begin
      failures++; $display("FAIL b2b_period red=%0d got %0d exp %0d", red, second - first, red ? 7 : 6);
    end
    checks++; if (!seen_y || y_first !== PW'(15)) begin failures++; $display("FAIL b2b_y red=%0d got %h exp 15", red, y_first); end
  endtask

  task automatic test_random();
    logic [PW-1:0] yv; logic [384:0] r; int lat; bit red;
    logic [W-1:0] x, z;
    for (int n = 0; n < 30; n++) begin
      x = rnd193(); z = rnd193(); red = 1'($urandom_range(0, 1));
      if (n % 5 == 0) x = x & {W{1'b0}} | (W'(1) << $urandom_range(0, W - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(x, z, red, yv, lat);
      r = ref_mul(x, z, W, 193'h8001, red);
      checks++; if (yv !== r[PW-1:0] || lat !== (red ? 5 : 4)) begin
        failures++; $display("FAIL rand193 n=%0d red=%0d lat=%0d got %h exp %h", n, red, lat, yv, r[PW-1:0]);
      end
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] z, input bit red, output logic [14:0] yv);
    bit ok; ok = 1'b0; yv = 'x;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = io8.in_ready;
    end
    io8.in_valid = 1'b1; io8.a = x; io8.b = z; io8.reduce = red;
    @(posedge clk);
    #1 io8.in_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (io8.out_valid) begin yv = io8.y; break; end
    end
    io8.out_ready = 1'b1;
    @(posedge clk);
    #1 io8.out_ready = 1'b0;
  endtask

  task automatic test_w8();
    logic [14:0] yv; logic [384:0] r; logic [7:0] x, z; bit red;
    op8(8'h57, 8'h83, 1'b0, yv);
    checks++; if (yv !== 15'h2B79) begin failures++; $display("FAIL aes_raw got %h exp 2b79", yv); end
    op8(8'h57, 8'h83, 1'b1, yv);
    checks++; if (yv !== 15'h00C1) begin failures++; $display("FAIL aes_red got %h exp 00c1", yv); end
    for (int n = 0; n < 20; n++) begin
      x = 8'($urandom_range(0, 255)); z = 8'($urandom_range(0, 255)); red = 1'($urandom_range(0, 1));
      op8(x, z, red, yv);
      r = ref_mul(193'(x), 193'(z), 8, 193'h1B, red);
      checks++; if (yv !== r[14:0]) begin failures++; $display("FAIL rand8 %h*%h red=%0d got %h exp %h", x, z, red, yv, r[14:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_raw_one();
    test_reduce();
    test_square();
    test_backpressure();
    test_reset_mid();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random();
    test_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
